// File: rtl/green_cell_pkg.sv
// Shared types and helpers for the Game of Life cell controllers.
package green_cell_pkg;

  typedef enum logic [1:0] {
    SETUP_OFF = 2'd0,
    SETUP_ON  = 2'd1,
    GAME_ON   = 2'd2,
    GAME_OFF  = 2'd3
  } cell_state_t;

  localparam int unsigned DEFAULT_TICK_DIV = 33_333_333;
  localparam int unsigned NBR_W            = 8;
  localparam int unsigned CNT_W            = 4;

  // Number of live neighbours, 0..8.
  function automatic logic [CNT_W-1:0] neighbour_count(input logic [NBR_W-1:0] nbrs);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < int'(NBR_W); i++) begin
      sum = sum + CNT_W'(nbrs[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/tick_enable_gen.sv
// Slow clock-enable: one-cycle tick every TICK_DIV clocks, phase reset by reset.
module tick_enable_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_count;

  assign tick = (r_count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/green_seed_light_fsm.sv
// One matrix cell: seeded during setup, then evolves by Conway rules once per tick.
module green_seed_light_fsm
  import green_cell_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic gl,
  input  logic gla,
  input  logic ga,
  input  logic gra,
  input  logic gr,
  input  logic grb,
  input  logic gb,
  input  logic glb,
  input  logic selectingLightConfirmed,
  input  logic startGameSwitch,
  output logic greenLED
);

  logic             w_tick;
  logic [CNT_W-1:0] w_n;
  cell_state_t      w_ns;
  cell_state_t      r_state;
  logic             r_led;

  tick_enable_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_n = neighbour_count({gl, gla, ga, gra, gr, grb, gb, glb});

  function automatic cell_state_t next_state(
    input cell_state_t      cur,
    input logic [CNT_W-1:0] n,
    input logic             confirm,
    input logic             start
  );
    cell_state_t ns;
    ns = SETUP_OFF;
    case (cur)
      SETUP_OFF: ns = start ? GAME_OFF : (confirm ? SETUP_ON : SETUP_OFF);
      SETUP_ON:  ns = start ? GAME_ON : SETUP_ON;
      GAME_ON:   ns = ((n == CNT_W'(2)) || (n == CNT_W'(3))) ? GAME_ON : GAME_OFF;
      GAME_OFF:  ns = (n == CNT_W'(3)) ? GAME_ON : GAME_OFF;
      default:   ns = SETUP_OFF;
    endcase
    return ns;
  endfunction

  assign w_ns = next_state(r_state, w_n, selectingLightConfirmed, startGameSwitch);

  // LED flop is loaded from the next state, so it tracks the state with no added latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SETUP_OFF;
      r_led   <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_ns;
      r_led   <= (w_ns == SETUP_ON) || (w_ns == GAME_ON);
    end
  end

  assign greenLED = r_led;

endmodule

// File: tb/tb_green_seed_light_fsm.sv
// Bench for green_seed_light_fsm against a cell-level Game of Life model.
module tb_green_seed_light_fsm;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic reset;
  logic gl, gla, ga, gra, gr, grb, gb, glb;
  logic selectingLightConfirmed;
  logic startGameSwitch;
  logic greenLED;

  int checks   = 0;
  int failures = 0;

  // Model: cell is alive/dead and either in setup or in the game; phase counts clocks since reset.
  bit m_alive;
  bit m_game;
  int m_phase;

  green_seed_light_fsm #(.TICK_DIV(TD)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .gl                      (gl),
    .gla                     (gla),
    .ga                      (ga),
    .gra                     (gra),
    .gr                      (gr),
    .grb                     (grb),
    .gb                      (gb),
    .glb                     (glb),
    .selectingLightConfirmed (selectingLightConfirmed),
    .startGameSwitch         (startGameSwitch),
    .greenLED                (greenLED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (greenLED === exp) else begin
      failures++;
      $error("FAIL %s: greenLED observed=%b expected=%b", tag, greenLED, exp);
    end
  endtask

  task automatic set_nbrs(input logic [7:0] v);
    {gl, gla, ga, gra, gr, grb, gb, glb} = v;
  endtask

  task automatic model_edge();
    int n;
    if (reset) begin
      m_alive = 1'b0;
      m_game  = 1'b0;
      m_phase = 0;
    end else begin
      if (m_phase == int'(TD) - 1) begin
        if (!m_game) begin
          if (startGameSwitch) m_game = 1'b1;
          else if (selectingLightConfirmed) m_alive = 1'b1;
        end else begin
          n = $countones({gl, gla, ga, gra, gr, grb, gb, glb});
          m_alive = (n == 3) || (m_alive && n == 2);
        end
      end
      m_phase = (m_phase + 1) % int'(TD);
    end
  endtask

  task automatic cycles(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check(tag, m_alive);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2, "reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    selectingLightConfirmed = 1'b0;
    startGameSwitch = 1'b0;
    set_nbrs(8'h00);
    m_alive = 1'b0; m_game = 1'b0; m_phase = 0;

    // Start with no seed: dead game cell.
    do_reset();
    check("reset_led_low", 1'b0);
    startGameSwitch = 1'b1;
    cycles(TD, "start_unseeded");
    startGameSwitch = 1'b0;
    cycles(8, "game_off_n0");
    check("game_off_stays_dark", 1'b0);

    // Seed the cell in setup.
    do_reset();
    selectingLightConfirmed = 1'b1;
    cycles(TD, "seed_confirm");
    check("seed_lit", 1'b1);
    selectingLightConfirmed = 1'b0;
    cycles(40, "seed_hold");
    check("seed_held", 1'b1);

    // Start the game from a seeded cell and walk the Conway rules.
    startGameSwitch = 1'b1;
    cycles(TD, "start_seeded");
    startGameSwitch = 1'b0;
    set_nbrs(8'b1110_0000);
    cycles(12, "survive_n3");
    check("survive_n3_lit", 1'b1);
    set_nbrs(8'b1000_0000);
    cycles(8, "die_n1");
    check("die_n1_dark", 1'b0);
    set_nbrs(8'b1110_0000);
    cycles(8, "birth_n3");
    check("birth_n3_lit", 1'b1);
    set_nbrs(8'b1111_0000);
    cycles(8, "die_n4");
    check("die_n4_dark", 1'b0);
    set_nbrs(8'b1100_0000);
    cycles(8, "dead_n2");
    check("dead_n2_dark", 1'b0);
    set_nbrs(8'hFF);
    cycles(8, "dead_n8");

    // One-cycle confirm pulse that misses the tick edge.
    set_nbrs(8'h00);
    do_reset();
    cycles(1, "align");
    selectingLightConfirmed = 1'b1;
    cycles(1, "short_pulse");
    selectingLightConfirmed = 1'b0;
    cycles(8, "short_pulse_ignored");
    check("short_pulse_dark", 1'b0);

    // Reset while alive in the game, then first tick timing after release.
    selectingLightConfirmed = 1'b1;
    cycles(TD, "reseed");
    selectingLightConfirmed = 1'b0;
    startGameSwitch = 1'b1;
    cycles(TD, "restart");
    startGameSwitch = 1'b0;
    set_nbrs(8'b0011_1000);
    cycles(1, "pre_reset");
    reset = 1'b1;
    cycles(1, "mid_game_reset");
    check("mid_game_reset_dark", 1'b0);
    reset = 1'b0;
    selectingLightConfirmed = 1'b1;
    cycles(TD - 1, "before_first_tick");
    check("before_first_tick_dark", 1'b0);
    cycles(1, "first_tick");
    check("first_tick_lit", 1'b1);
    selectingLightConfirmed = 1'b0;

    // Randomized play with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] v;
      for (int b = 0; b < 8; b++) v[b] = ($urandom_range(7) < 3);
      set_nbrs(v);
      selectingLightConfirmed = ($urandom_range(7) == 0);
      startGameSwitch = ($urandom_range(31) == 0);
      reset = ($urandom_range(199) == 0);
      cycles(1, "random");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
